// File: rtl/seq_frame_serializer_if.sv
// Frame handshake and serial output bundle for seq_frame_serializer.
// The serializer uses the slave side of the bundle; the feeder or bench uses the master side.
interface seq_frame_serializer_if #(
  parameter int FRAME_W = 6,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic [FRAME_W-1:0] in_data;
  logic               in_ready;
  logic               data;
  logic               data_valid;
  logic               frame_start;
  logic [CNT_W-1:0]   fifo_count;

  modport master (
    output in_valid, in_data,
    input  in_ready, data, data_valid, frame_start, fifo_count
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, data, data_valid, frame_start, fifo_count
  );
endinterface

// File: rtl/seq_frame_serializer.sv
// Buffers parallel frames in a small FIFO and shifts them out MSB-first, one bit per clock,
// with no idle bits between queued frames.
module seq_frame_serializer #(
  parameter int   FRAME_W  = 6,
  parameter int   DEPTH    = 4,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_frame_serializer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BC_W  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  state_t             state;
  logic [BC_W-1:0]    bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic               data_q;
  logic               data_valid_q;
  logic               frame_start_q;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               last_bit;
  logic [FRAME_W-1:0] head;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push     = bus.in_valid && !full;
  assign last_bit = (state == S_SHIFT) && (bit_cnt == BC_W'(FRAME_W - 1));
  // Popping on the last bit of the current frame lets the next frame follow with no gap.
  assign pop      = !empty && ((state == S_IDLE) || last_bit);
  assign head     = mem[rd_ptr];

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Shift register: holds the not-yet-transmitted bits of the frame in flight
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg <= {head[FRAME_W-2:0], 1'b0};
    end else if (state == S_SHIFT) begin
      shreg <= {shreg[FRAME_W-2:0], 1'b0};
    end
  end

  // Shifter control and registered serial outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      bit_cnt       <= '0;
      data_q        <= IDLE_BIT;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pop) begin
      state         <= S_SHIFT;
      bit_cnt       <= '0;
      data_q        <= head[FRAME_W-1];
      data_valid_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else if (state == S_SHIFT) begin
      if (last_bit) begin
        state         <= S_IDLE;
        bit_cnt       <= '0;
        data_q        <= IDLE_BIT;
        data_valid_q  <= 1'b0;
        frame_start_q <= 1'b0;
      end else begin
        bit_cnt       <= bit_cnt + 1'b1;
        data_q        <= shreg[FRAME_W-1];
        frame_start_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = !full;
  assign bus.data        = data_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.fifo_count  = count;
endmodule

// File: tb/tb_seq_frame_serializer.sv
// Self-checking bench for seq_frame_serializer: randomized frames scored against a
// timeline model where each frame starts at max(push_edge+1, previous_start+FRAME_W).
module tb_seq_frame_serializer;
  localparam int   FW    = 6;
  localparam int   DEPTH = 4;
  localparam logic IDLE  = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_frame_serializer_if #(.FRAME_W(FW), .DEPTH(DEPTH)) bus ();

  seq_frame_serializer #(.FRAME_W(FW), .DEPTH(DEPTH), .IDLE_BIT(IDLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference model: one entry per accepted frame
  int          push_e [$];
  int          start_e[$];
  logic [FW-1:0] frm  [$];

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected {data, data_valid, frame_start, fifo_count, in_ready} after edge n
  function automatic logic [6:0] model_out(int n);
    int   cnt = 0;
    logic d   = IDLE;
    logic dv  = 1'b0;
    logic fs  = 1'b0;
    foreach (push_e[k]) begin
      if (push_e[k] <= n && start_e[k] > n) cnt++;
      if (start_e[k] <= n && n < start_e[k] + FW) begin
        dv = 1'b1;
        d  = frm[k][FW-1-(n-start_e[k])];
        fs = (n == start_e[k]);
      end
    end
    return {d, dv, fs, 3'(cnt), (cnt < DEPTH)};
  endfunction

  function automatic logic [6:0] obs();
    return {bus.data, bus.data_valid, bus.frame_start, bus.fifo_count, bus.in_ready};
  endfunction

  task automatic model_clear();
    push_e.delete();
    start_e.delete();
    frm.delete();
  endtask

  // Drives one cycle of stimulus and records an accepted frame in the model
  task automatic drive_cycle(input logic v, input logic [FW-1:0] d, output logic pushed);
    logic [6:0] m;
    int s;
    m = model_out(edge_n);
    bus.in_valid = v;
    bus.in_data  = d;
    pushed = v && m[0];
    @(posedge clk);
    #1;
    if (pushed) begin
      s = edge_n + 1;
      if (start_e.size() > 0 && start_e[$] + FW > s) s = start_e[$] + FW;
      push_e.push_back(edge_n);
      start_e.push_back(s);
      frm.push_back(d);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (obs() !== 7'b1_0_0_000_1) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected %b", obs(), 7'b1_0_0_000_1);
    end
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    tests_run++;
    if (obs() !== model_out(edge_n)) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got %b expected %b", obs(), model_out(edge_n));
    end
  endtask

  task automatic test_single_frame();
    logic        p;
    logic [FW-1:0] bits;
    int nbits, nfs;
    nbits = 0; nfs = 0; bits = '0;
    drive_cycle(1'b1, 6'b011100, p);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, '0, p);
      tests_run++;
      if (obs() !== model_out(edge_n)) begin
        tests_failed++;
        $display("FAIL single_cycle%0d: got %b expected %b", i, obs(), model_out(edge_n));
      end
      if (bus.data_valid) begin
        bits = {bits[FW-2:0], bus.data};
        nbits++;
      end
      if (bus.frame_start) nfs++;
    end
    tests_run++;
    if (bits !== 6'b011100 || nbits != 6 || nfs != 1) begin
      tests_failed++;
      $display("FAIL single_stream: got bits=%b n=%0d fs=%0d expected 011100 n=6 fs=1", bits, nbits, nfs);
    end
  endtask

  task automatic test_back_to_back();
    logic p;
    logic [11:0] bits;
    int nbits, first_fs, second_fs, t0;
    bits = '0; nbits = 0; first_fs = -1; second_fs = -1;
    t0 = edge_n + 1;
    drive_cycle(1'b1, 6'b011100, p);
    drive_cycle(1'b1, 6'b101010, p);
    for (int i = 0; i < 14; i++) begin
      if (i > 0) drive_cycle(1'b0, '0, p);
      tests_run++;
      if (obs() !== model_out(edge_n)) begin
        tests_failed++;
        $display("FAIL b2b_cycle%0d: got %b expected %b", i, obs(), model_out(edge_n));
      end
      if (bus.data_valid) begin
        bits = {bits[10:0], bus.data};
        nbits++;
      end
      if (bus.frame_start) begin
        if (first_fs < 0) first_fs = edge_n - t0;
        else second_fs = edge_n - t0;
      end
    end
    tests_run++;
    if (bits !== 12'b011100101010 || nbits != 12 || first_fs != 1 || second_fs != 7) begin
      tests_failed++;
      $display("FAIL b2b_stream: got bits=%b n=%0d fs@%0d,%0d expected 011100101010 n=12 fs@1,7",
               bits, nbits, first_fs, second_fs);
    end
  endtask

  task automatic test_backpressure();
    logic p;
    logic [FW-1:0] fr [10];
    logic [FW-1:0] base;
    int idx, max_cnt, c1, c2, cyc;
    logic saw_434;
    base = FW'($urandom);
    for (int i = 0; i < 10; i++) fr[i] = base + FW'(i * 5);
    idx = 0; max_cnt = 0; c1 = -1; c2 = -1; saw_434 = 1'b0; cyc = 0;
    while (cyc < 200 && !(idx == 10 && model_out(edge_n) == 7'b1_0_0_000_1)) begin
      drive_cycle(idx < 10, (idx < 10) ? fr[idx] : '0, p);
      if (p) idx++;
      cyc++;
      tests_run++;
      if (obs() !== model_out(edge_n)) begin
        tests_failed++;
        $display("FAIL bp_cycle%0d: got %b expected %b", cyc, obs(), model_out(edge_n));
      end
      if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
      if (c2 == 4 && c1 == 3 && bus.fifo_count == 3'd4) saw_434 = 1'b1;
      c2 = c1;
      c1 = int'(bus.fifo_count);
    end
    tests_run++;
    if (idx != 10 || max_cnt != 4 || !saw_434) begin
      tests_failed++;
      $display("FAIL bp_summary: got pushed=%0d max=%0d saw434=%0b expected 10 4 1", idx, max_cnt, saw_434);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic p;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, FW'($urandom), p);
    tests_run++;
    if (obs() !== model_out(edge_n) || bus.fifo_count !== 3'd3) begin
      tests_failed++;
      $display("FAIL midrst_pre: got %b expected %b with count 3", obs(), model_out(edge_n));
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (obs() !== 7'b1_0_0_000_1) begin
      tests_failed++;
      $display("FAIL midrst_async: got %b expected %b", obs(), 7'b1_0_0_000_1);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, '0, p);
      tests_run++;
      if (obs() !== model_out(edge_n)) begin
        tests_failed++;
        $display("FAIL midrst_stale%0d: got %b expected %b", i, obs(), model_out(edge_n));
      end
    end
  endtask

  task automatic test_pointer_wrap();
    logic p;
    logic [FW-1:0] d;
    int nfs, tries, gap;
    nfs = 0;
    for (int f = 0; f < 3 * DEPTH + 1; f++) begin
      gap = $urandom_range(0, 8);
      for (int g = 0; g < gap; g++) begin
        drive_cycle(1'b0, '0, p);
        tests_run++;
        if (obs() !== model_out(edge_n)) begin
          tests_failed++;
          $display("FAIL wrap_gap f%0d: got %b expected %b", f, obs(), model_out(edge_n));
        end
        if (bus.frame_start) nfs++;
      end
      d = FW'($urandom);
      p = 1'b0;
      tries = 0;
      while (!p && tries < 50) begin
        drive_cycle(1'b1, d, p);
        tries++;
        tests_run++;
        if (obs() !== model_out(edge_n)) begin
          tests_failed++;
          $display("FAIL wrap_push f%0d: got %b expected %b", f, obs(), model_out(edge_n));
        end
        if (bus.frame_start) nfs++;
      end
    end
    for (int i = 0; i < (DEPTH + 2) * FW; i++) begin
      drive_cycle(1'b0, '0, p);
      tests_run++;
      if (obs() !== model_out(edge_n)) begin
        tests_failed++;
        $display("FAIL wrap_drain%0d: got %b expected %b", i, obs(), model_out(edge_n));
      end
      if (bus.frame_start) nfs++;
    end
    tests_run++;
    if (nfs != 3 * DEPTH + 1) begin
      tests_failed++;
      $display("FAIL wrap_frames: got %0d frames expected %0d", nfs, 3 * DEPTH + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_pointer_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/seq_frame_serializer.md
# seq_frame_serializer

Upstream feeder for the serial sequence detector. It accepts parallel FRAME_W-bit frames over a valid/ready handshake and buffers them in a small FIFO. It shifts each frame out MSB-first, one bit per clock, on a single-bit `data` line. Back-to-back frames produce a gap-free bitstream, so the detector downstream sees contiguous frame-aligned groups.

## Interface
- FRAME_W, 6: bits per frame; matches the detector's group length.
- DEPTH, 4: FIFO entries; must be a power of two and at least 2.
- IDLE_BIT, 1'b1: value driven on `data` when no frame is being shifted.
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a frame on in_data.
- in_data  input  FRAME_W  frame; bit FRAME_W-1 is transmitted first.
- in_ready  output  1  FIFO can accept a frame (combinational from count: `!full`).
- data  output  1  registered serial bit to the detector.
- data_valid  output  1  registered; `data` carries a frame bit this cycle.
- frame_start  output  1  registered; high on the first (MSB) bit of each frame.
- fifo_count  output  $clog2(DEPTH)+1  registered FIFO occupancy, 0..DEPTH.

## Operation
- **Push.** A push occurs when `in_valid && in_ready` at a clock edge; the frame is written at the tail. Pushes are never dropped silently because in_ready=0 when fifo_count==DEPTH. A push while full is impossible by construction.
- **Shifter states.**
  - IDLE: no frame in flight; data=IDLE_BIT, data_valid=0.
  - SHIFT: bit_cnt 0..FRAME_W-1 indexes the current bit.
- **Pop condition.** Pop when FIFO is non-empty AND (state==IDLE OR (state==SHIFT AND bit_cnt==FRAME_W-1)).
- **On pop, at the edge:**
  - data <= word[FRAME_W-1]
  - shreg <= word shifted left by 1
  - bit_cnt <= 0, frame_start <= 1, data_valid <= 1, state <= SHIFT
- **In SHIFT without pop:** data <= shreg MSB; shreg shifts left; bit_cnt++; frame_start <= 0.
- **Frame end with empty FIFO.** In SHIFT with bit_cnt==FRAME_W-1 and the FIFO empty: state <= IDLE, data <= IDLE_BIT, data_valid <= 0, frame_start <= 0.
- **Simultaneous push and pop.** Count is unchanged; the popped entry is the old head. A push into an empty FIFO is not bypassed and pops at the next edge.
- **Count update.** fifo_count changes by +1 (push only), -1 (pop only), or 0 (both or neither).
- **Pointers.** Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- **Reset.** Asynchronous reset, including mid-frame: the in-flight partial frame is abandoned and the FIFO is flushed.
  - data=IDLE_BIT, data_valid=0, frame_start=0, fifo_count=0, in_ready=1, state=IDLE, bit_cnt=0, pointers=0.
  - After rst deasserts, the first push can occur at the next edge.

## Timing
- **Latency.** A push at edge t into an empty FIFO with the shifter IDLE puts the first bit on `data` after edge t+1. Bit i is visible after edge t+1+i, for i=0..FRAME_W-1.
- **Throughput.** One frame per FRAME_W cycles sustained, with zero idle bits between queued frames.
- **Capacity.** Total buffering is DEPTH queued frames plus one frame in the shifter.
- **in_ready.** Reflects the registered fifo_count, so it rises the cycle after a pop frees a slot.
- **frame_start.** Exactly one cycle wide per frame, coincident with the MSB on `data`.

## Test plan
- **Single frame.** Reset, then push 6'b011100 at edge 0. Required: data = 0,1,1,1,0,0 after edges 1..6; frame_start=1 only after edge 1; data_valid=1 for edges 1..6, then 0 with data=1.
- **Back-to-back frames.** Push 6'b011100 then 6'b101010 on consecutive edges. Required: 12 contiguous valid bits 011100101010; frame_start high after edges 1 and 7; no idle bit between frames.
- **Backpressure.** Hold in_valid=1 for 10 distinct frames. Required:
  - fifo_count saturates at 4 and in_ready=0 while full.
  - in_ready reasserts one cycle after each pop.
  - All 10 frames are emitted in order, with none duplicated or lost.
- **Simultaneous push/pop at full.** Full FIFO; a pop occurs at edge e while in_valid=1. Required: no push at e (in_ready=0 at e); push at e+1; fifo_count goes 4→3→4.
- **Reset mid-frame.** Assert rst after bit 2 of a frame with 3 frames queued. Required:
  - Outputs go immediately to data=1, data_valid=0, frame_start=0, fifo_count=0, in_ready=1.
  - After release, no stale bits are emitted.
- **Pointer wrap.** Push/pop 3×DEPTH+1 frames with random gaps. Required: serial output matches the pushed sequence exactly across pointer wrap.
